dcom_buffer_writer: RTL
=======================

DCOM_BUFFER_WRITER -- requirements
Module: dcom_buffer_writer

Interface
REQ-001 SHALL have parameter none; all widths fixed as listed below.
REQ-002 SHALL have port: clk50_clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst_reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: cmd_start_i  in  1  one-cycle pulse that starts a transfer.
REQ-005 SHALL have port: cmd_base_addr_i  in  12  first word address; sampled on accepted start.
REQ-006 SHALL have port: cmd_length_i  in  13  word count, 0..4096; sampled on accepted start.
REQ-007 SHALL have port: cmd_abort_i  in  1  abort request, level-sampled.
REQ-008 SHALL have port: src_data_i  in  64  source word.
REQ-009 SHALL have port: src_valid_i  in  1  source word valid.
REQ-010 SHALL have port: src_ready_o  out  1  source word accepted when valid and ready are both 1.
REQ-011 SHALL have port: avm_address_o  out  12  word address to dcom data buffer slave.
REQ-012 SHALL have port: avm_write_o  out  1  Avalon-MM write.
REQ-013 SHALL have port: avm_writedata_o  out  64  write data.
REQ-014 SHALL have port: avm_byteenable_o  out  8  byte lanes.
REQ-015 SHALL have port: avm_waitrequest_i  in  1  slave stall.
REQ-016 SHALL have port: busy_o  out  1  transfer in progress.
REQ-017 SHALL have port: words_written_o  out  13  words accepted by slave in current/last transfer.
REQ-018 SHALL have port: done_irq_o  out  1  sticky completion interrupt.
REQ-019 SHALL have port: irq_clear_i  in  1  clears done_irq_o.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_DATA, WRITE, DONE.
REQ-021 IDLE: busy_o=0, src_ready_o=0, avm_write_o=0; cmd_start_i with length!=0 -> latch base/length, clear words_written_o, go WAIT_DATA; length==0 -> go DONE.
REQ-022 cmd_start_i outside IDLE SHALL be ignored.
REQ-023 WAIT_DATA: src_ready_o=1, busy_o=1; on handshake register data, go WRITE; avm_write_o asserts the following cycle.
REQ-024 WRITE: avm_write_o=1, src_ready_o=0; address, writedata, byteenable SHALL stay stable while avm_waitrequest_i=1.
REQ-025 WRITE with avm_waitrequest_i=0: words_written_o+1, address+1 modulo 4096 (4095 wraps to 0); if words_written_o+1==length -> DONE else WAIT_DATA.
REQ-026 Throughput SHALL be one word per two cycles with zero waitrequest; handshake at cycle N, write accepted at N+1, next src_ready_o at N+2.
REQ-027 DONE: lasts one cycle, busy_o=0, sets done_irq_o, returns to IDLE.
REQ-028 cmd_abort_i in WAIT_DATA SHALL go to IDLE next cycle, no word consumed, done_irq_o unchanged.
REQ-029 cmd_abort_i in WRITE SHALL NOT drop the pending write; after acceptance go IDLE without DONE.
REQ-030 irq_clear_i SHALL clear done_irq_o; simultaneous set and clear SHALL leave done_irq_o=1.
REQ-031 words_written_o SHALL hold its value in IDLE until next accepted start.

Reset
REQ-032 rst_reset_n=0 at a rising edge SHALL force IDLE, all outputs 0, counters 0, done_irq_o=0, including mid-write (slave responsibility to tolerate).

Configuration
REQ-033 Macro DCOM_WRITER_BYTEENABLE_EN defined: add input cmd_last_be_i (8), latched on start, driven on avm_byteenable_o for the final word only; all other words 0xFF.
REQ-034 Macro undefined: no cmd_last_be_i port; avm_byteenable_o=0xFF whenever avm_write_o=1, 0x00 otherwise (both builds drive 0x00 when idle).

Verification
REQ-035 Start base=0x010 len=3, source always valid, waitrequest=0 -> writes at 0x010,0x011,0x012, done_irq_o=1 after 7 cycles, words_written_o=3.
REQ-036 Single word, waitrequest high 5 cycles -> avm_write_o high 6 cycles, address/data stable throughout, one write counted.
REQ-037 Base=0xFFE len=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-038 len=0 -> no avm_write_o, done_irq_o=1 two cycles after start; irq_clear_i same cycle as set -> stays 1.
REQ-039 Abort during WRITE on word 2 of 5 with waitrequest high -> write completes, IDLE, words_written_o=2, done_irq_o=0.
REQ-040 Reset asserted mid WRITE -> next cycle avm_write_o=0, busy_o=0, words_written_o=0; with macro, len=2 last_be=0x0F -> byteenables 0xFF then 0x0F.

Source files
------------

// File: rtl/dcom_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : dcom_buffer_writer
// Purpose  : Copies a burst of 64-bit words from a valid/ready source into the
//            dcom data buffer over an Avalon-MM write master. One word is
//            moved every two cycles when the slave does not stall.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk50_clk          in   1   clock, rising edge
//   rst_reset_n        in   1   synchronous active-low reset
//   cmd_start_i        in   1   start pulse (honoured only when idle)
//   cmd_base_addr_i    in  12   first word address
//   cmd_length_i       in  13   word count 0..4096
//   cmd_abort_i        in   1   abort request (level)
//   src_data_i         in  64   source word
//   src_valid_i        in   1   source word valid
//   src_ready_o        out  1   source word accepted on valid & ready
//   avm_address_o      out 12   buffer word address
//   avm_write_o        out  1   Avalon-MM write strobe
//   avm_writedata_o    out 64   write data
//   avm_byteenable_o   out  8   byte lanes
//   avm_waitrequest_i  in   1   slave stall
//   busy_o             out  1   transfer in progress
//   words_written_o    out 13   words accepted by the slave
//   done_irq_o         out  1   sticky completion interrupt
//   irq_clear_i        in   1   clears done_irq_o
//   cmd_last_be_i      in   8   final-word byte enables (optional build)
// Build option
//   DCOM_WRITER_BYTEENABLE_EN : adds cmd_last_be_i, applied to the last word.
// ============================================================================
module dcom_buffer_writer (
    input  logic        clk50_clk,
    input  logic        rst_reset_n,
    input  logic        cmd_start_i,
    input  logic [11:0] cmd_base_addr_i,
    input  logic [12:0] cmd_length_i,
    input  logic        cmd_abort_i,
    input  logic [63:0] src_data_i,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    output logic [11:0] avm_address_o,
    output logic        avm_write_o,
    output logic [63:0] avm_writedata_o,
    output logic [7:0]  avm_byteenable_o,
    input  logic        avm_waitrequest_i,
    output logic        busy_o,
    output logic [12:0] words_written_o,
    output logic        done_irq_o,
    input  logic        irq_clear_i
`ifdef DCOM_WRITER_BYTEENABLE_EN
    ,
    input  logic [7:0]  cmd_last_be_i
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_WRITE     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] addr_q;
    logic [12:0] length_q;
    logic [12:0] words_q;
    logic [63:0] data_q;
    logic        done_irq_q;
    logic        abort_q;     // abort seen while a write was stalled
    logic        handshake;
    logic        write_accept;
    logic        last_word;
`ifdef DCOM_WRITER_BYTEENABLE_EN
    logic [7:0]  last_be_q;
`endif

    assign last_word = (words_q + 13'd1) == length_q;

    always_comb begin
        state_nxt    = state;
        src_ready_o  = 1'b0;
        avm_write_o  = 1'b0;
        busy_o       = 1'b0;
        handshake    = 1'b0;
        write_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_start_i) begin
                    state_nxt = (cmd_length_i == 13'd0) ? ST_DONE : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                busy_o = 1'b1;
                // Ready is withheld during abort so no word is consumed.
                src_ready_o = ~cmd_abort_i;
                handshake   = src_valid_i & ~cmd_abort_i;
                if (cmd_abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (src_valid_i) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy_o       = 1'b1;
                avm_write_o  = 1'b1;
                write_accept = ~avm_waitrequest_i;
                if (!avm_waitrequest_i) begin
                    // An abort never cancels a write already on the bus.
                    if (abort_q || cmd_abort_i) begin
                        state_nxt = ST_IDLE;
                    end else if (last_word) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT_DATA;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50_clk) begin
        if (!rst_reset_n) begin
            state      <= ST_IDLE;
            addr_q     <= 12'd0;
            length_q   <= 13'd0;
            words_q    <= 13'd0;
            data_q     <= 64'd0;
            done_irq_q <= 1'b0;
            abort_q    <= 1'b0;
`ifdef DCOM_WRITER_BYTEENABLE_EN
            last_be_q  <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cmd_start_i) begin
                addr_q   <= cmd_base_addr_i;
                length_q <= cmd_length_i;
                words_q  <= 13'd0;
                abort_q  <= 1'b0;
`ifdef DCOM_WRITER_BYTEENABLE_EN
                last_be_q <= cmd_last_be_i;
`endif
            end
            if (handshake) begin
                data_q <= src_data_i;
            end
            if (state == ST_WRITE && cmd_abort_i) begin
                abort_q <= 1'b1;
            end
            if (write_accept) begin
                words_q <= words_q + 13'd1;
                addr_q  <= addr_q + 12'd1;   // natural 12-bit wrap 0xFFF -> 0x000
            end
            // Set has priority over clear.
            if (state == ST_DONE) begin
                done_irq_q <= 1'b1;
            end else if (irq_clear_i) begin
                done_irq_q <= 1'b0;
            end
        end
    end

    assign avm_address_o   = addr_q;
    assign avm_writedata_o = data_q;
    assign words_written_o = words_q;
    assign done_irq_o      = done_irq_q;

`ifdef DCOM_WRITER_BYTEENABLE_EN
    assign avm_byteenable_o = !avm_write_o ? 8'h00 : (last_word ? last_be_q : 8'hFF);
`else
    assign avm_byteenable_o = avm_write_o ? 8'hFF : 8'h00;
`endif

endmodule
`default_nettype wire
